// File: rtl/micromotion_histogram.sv
// Photon-phase histogram: clear, acquire for a programmed window, stream bins out; bin updates land 1 clk after the detect.
// Readout is valid/ready with registered valid; words hold under backpressure, 1 word/clk when ready stays high.
module micromotion_histogram #(
    parameter int DATASIZE   = 8,
    parameter int NBINS_LOG2 = 4,
    parameter int BIN_SHIFT  = 2,
    parameter int COUNTSIZE  = 16,
    parameter int WINSIZE    = 32
) (
    input  logic                  c_clk,
    input  logic                  c_rst,
    input  logic                  c_detect,
    input  logic [DATASIZE-1:0]   c_diff,
    input  logic [DATASIZE-1:0]   c_ch2_period,
    input  logic                  c_start,
    input  logic [WINSIZE-1:0]    c_win_len,
    output logic                  c_busy,
    output logic                  c_rd_valid,
    input  logic                  c_rd_ready,
    output logic [NBINS_LOG2-1:0] c_rd_bin,
    output logic [COUNTSIZE-1:0]  c_rd_count,
    output logic                  c_rd_last,
    output logic [COUNTSIZE-1:0]  c_ovf_count,
    output logic [DATASIZE-1:0]   c_period_snap,
    output logic                  c_done
);

    localparam int NBINS = 1 << NBINS_LOG2;
    localparam logic [NBINS_LOG2-1:0] LAST_BIN = NBINS_LOG2'(NBINS - 1);
    localparam logic [COUNTSIZE-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ACQUIRE,
        S_READOUT
    } state_t;

    state_t                state_q, state_d;
    logic [NBINS_LOG2-1:0] clr_q, clr_d;
    logic [NBINS_LOG2-1:0] ptr_q, ptr_d;
    logic [WINSIZE-1:0]    win_q, win_d;
    logic [COUNTSIZE-1:0]  ovf_q, ovf_d;
    logic [DATASIZE-1:0]   snap_q, snap_d;
    logic                  done_q, done_d;
    logic [COUNTSIZE-1:0]  bins_q [NBINS];

    logic [DATASIZE-1:0]   shifted;
    logic                  in_range;
    logic [NBINS_LOG2-1:0] det_bin;
    logic                  acq_hit;
    logic                  win_last;

    // A bin index is in range when nothing survives above the low NBINS_LOG2 bits.
    assign shifted  = c_diff >> BIN_SHIFT;
    assign in_range = (shifted >> NBINS_LOG2) == '0;
    assign det_bin  = shifted[NBINS_LOG2-1:0];
    assign acq_hit  = (state_q == S_ACQUIRE) && c_detect;
    assign win_last = (win_q == WINSIZE'(1));

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        ovf_d   = ovf_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (c_start) begin
                    state_d = S_CLEAR;
                    clr_d   = '0;
                    ptr_d   = '0;
                    ovf_d   = '0;
                    win_d   = (c_win_len == '0) ? WINSIZE'(1) : c_win_len;
                end
            end
            S_CLEAR: begin
                clr_d = clr_q + NBINS_LOG2'(1);
                if (clr_q == LAST_BIN) begin
                    state_d = S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                win_d = win_q - WINSIZE'(1);
                if (acq_hit && !in_range && (ovf_q != CNT_MAX)) begin
                    ovf_d = ovf_q + COUNTSIZE'(1);
                end
                if (win_last) begin
                    state_d = S_READOUT;
                    snap_d  = c_ch2_period;
                    ptr_d   = '0;
                end
            end
            S_READOUT: begin
                if (c_rd_ready) begin
                    ptr_d = ptr_q + NBINS_LOG2'(1);
                    if (ptr_q == LAST_BIN) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (c_rst) begin
            state_q <= S_IDLE;
            clr_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            ovf_q   <= '0;
            snap_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            ovf_q   <= ovf_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
        end
    end

    // Bin storage is not reset; CLEAR walks one bin per cycle. Each bin does its own
    // read-modify-write every cycle, so back-to-back hits to one bin never lose an update.
    always_ff @(posedge c_clk) begin
        for (int i = 0; i < NBINS; i++) begin
            if ((state_q == S_CLEAR) && (clr_q == NBINS_LOG2'(i))) begin
                bins_q[i] <= '0;
            end else if (acq_hit && in_range && (det_bin == NBINS_LOG2'(i))
                         && (bins_q[i] != CNT_MAX)) begin
                bins_q[i] <= bins_q[i] + COUNTSIZE'(1);
            end
        end
    end

    assign c_busy        = (state_q != S_IDLE);
    assign c_rd_valid    = (state_q == S_READOUT);
    assign c_rd_bin      = ptr_q;
    assign c_rd_count    = c_rd_valid ? bins_q[ptr_q] : '0;
    assign c_rd_last     = c_rd_valid && (ptr_q == LAST_BIN);
    assign c_ovf_count   = ovf_q;
    assign c_period_snap = snap_q;
    assign c_done        = done_q;

endmodule

// File: tb/tb_micromotion_histogram.sv
// Directed bench for micromotion_histogram: a default instance plus a COUNTSIZE=4 instance
// driven in lockstep from the same stimulus, so saturation is observable on the narrow one.
module tb_micromotion_histogram;

    logic        c_clk = 1'b0;
    logic        c_rst = 1'b1;
    logic        c_detect = 1'b0;
    logic [7:0]  c_diff = '0;
    logic [7:0]  c_ch2_period = '0;
    logic        c_start = 1'b0;
    logic [31:0] c_win_len = '0;
    logic        c_rd_ready = 1'b0;

    logic        c_busy, c_rd_valid, c_rd_last, c_done;
    logic [3:0]  c_rd_bin;
    logic [15:0] c_rd_count, c_ovf_count;
    logic [7:0]  c_period_snap;

    logic        s_busy, s_rd_valid, s_rd_last, s_done;
    logic [3:0]  s_rd_bin;
    logic [3:0]  s_rd_count, s_ovf_count;
    logic [7:0]  s_period_snap;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  det_q[$];
    int          exp_h[16];
    logic [15:0] hist[16];
    logic [3:0]  hist_s[16];

    micromotion_histogram dut (
        .c_clk(c_clk), .c_rst(c_rst), .c_detect(c_detect), .c_diff(c_diff),
        .c_ch2_period(c_ch2_period), .c_start(c_start), .c_win_len(c_win_len),
        .c_busy(c_busy), .c_rd_valid(c_rd_valid), .c_rd_ready(c_rd_ready),
        .c_rd_bin(c_rd_bin), .c_rd_count(c_rd_count), .c_rd_last(c_rd_last),
        .c_ovf_count(c_ovf_count), .c_period_snap(c_period_snap), .c_done(c_done)
    );

    micromotion_histogram #(.COUNTSIZE(4)) dut_s (
        .c_clk(c_clk), .c_rst(c_rst), .c_detect(c_detect), .c_diff(c_diff),
        .c_ch2_period(c_ch2_period), .c_start(c_start), .c_win_len(c_win_len),
        .c_busy(s_busy), .c_rd_valid(s_rd_valid), .c_rd_ready(c_rd_ready),
        .c_rd_bin(s_rd_bin), .c_rd_count(s_rd_count), .c_rd_last(s_rd_last),
        .c_ovf_count(s_ovf_count), .c_period_snap(s_period_snap), .c_done(s_done)
    );

    always #5 c_clk = ~c_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] len);
        c_win_len = len;
        c_start   = 1'b1;
        tick();
        c_start   = 1'b0;
        check("busy_after_start", c_busy, 1);
        check("ovf_zeroed_on_start", c_ovf_count, 0);
    endtask

    // Runs exactly w ACQUIRE cycles; det_q[k] is the c_diff of a detect on cycle k.
    task automatic acquire(input int w);
        for (int k = 0; k < w; k++) begin
            c_detect = (k < det_q.size());
            c_diff   = (k < det_q.size()) ? det_q[k] : 8'd0;
            tick();
        end
        c_detect = 1'b0;
    endtask

    // Entered on the first READOUT cycle; drains all 16 words.
    task automatic readout(input bit rnd);
        int e = 0;
        int cyc = 0;
        bit stalled = 0;
        logic [15:0] held = '0;
        while (e < 16 && cyc < 400) begin
            c_rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("rd_valid", c_rd_valid, 1);
            check("rd_bin", c_rd_bin, e);
            check("rd_last", c_rd_last, (e == 15));
            if (stalled) check("rd_hold", c_rd_count, held);
            if (c_rd_ready) begin
                hist[e]   = c_rd_count;
                hist_s[e] = s_rd_count;
                e++;
                stalled = 0;
            end else begin
                held    = c_rd_count;
                stalled = 1;
            end
            tick();
            c_detect = 1'b0;
            cyc++;
        end
        c_rd_ready = 1'b0;
        check("rd_words", e, 16);
        if (!rnd) check("rd_cycles", cyc, 16);
        check("done_pulse", c_done, 1);
        check("valid_drop", c_rd_valid, 0);
        check("busy_drop", c_busy, 0);
        tick();
        check("done_once", c_done, 0);
    endtask

    task automatic check_hists();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("hist%0d", i), hist[i], exp_h[i]);
            check($sformatf("sat_hist%0d", i), hist_s[i], (exp_h[i] > 15) ? 15 : exp_h[i]);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) exp_h[i] = 0;
    endtask

    initial begin
        // Reset, with a detect held during it
        c_detect = 1'b1;
        c_diff   = 8'd5;
        repeat (3) tick();
        c_rst    = 1'b0;
        c_detect = 1'b0;
        check("rst_busy", c_busy, 0);
        check("rst_valid", c_rd_valid, 0);
        check("rst_done", c_done, 0);
        check("rst_ovf", c_ovf_count, 0);
        check("rst_snap", c_period_snap, 0);
        check("rst_bin", c_rd_bin, 0);
        check("rst_count", c_rd_count, 0);
        check("rst_last", c_rd_last, 0);
        c_detect = 1'b1;
        c_diff   = 8'd5;
        tick();
        c_detect = 1'b0;
        check("idle_detect_busy", c_busy, 0);

        // Basic binning
        c_ch2_period = 8'd77;
        start_run(100);
        repeat (16) tick();
        det_q = '{8'd0, 8'd3, 8'd4, 8'd63, 8'd64};
        acquire(100);
        check("basic_snap", c_period_snap, 77);
        readout(0);
        clear_exp();
        exp_h[0] = 2; exp_h[1] = 1; exp_h[15] = 1;
        check_hists();
        check("basic_ovf", c_ovf_count, 1);

        // Back-to-back hits to one bin, random backpressure on readout
        start_run(20);
        repeat (16) tick();
        det_q = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
        acquire(20);
        readout(1);
        clear_exp();
        exp_h[2] = 10;
        check_hists();
        check("b2b_ovf", c_ovf_count, 0);

        // Window edges: length 0 acts as 1; detects in last CLEAR and first READOUT dropped
        start_run(0);
        repeat (15) tick();
        c_detect = 1'b1;
        c_diff   = 8'd0;
        tick();
        c_diff       = 8'd4;
        c_ch2_period = 8'd200;
        check("acq_busy", c_busy, 1);
        check("acq_not_valid", c_rd_valid, 0);
        tick();
        c_diff       = 8'd8;
        c_ch2_period = 8'd201;
        check("win1_valid", c_rd_valid, 1);
        check("win1_snap", c_period_snap, 200);
        readout(1);
        clear_exp();
        exp_h[1] = 1;
        check_hists();
        check("win1_snap_hold", c_period_snap, 200);

        // Saturation: narrow instance pins at 15
        start_run(40);
        repeat (16) tick();
        det_q.delete();
        for (int k = 0; k < 20; k++) det_q.push_back(8'd4);
        for (int k = 0; k < 20; k++) det_q.push_back(8'd255);
        acquire(40);
        readout(0);
        clear_exp();
        exp_h[1] = 20;
        check_hists();
        check("sat_ovf_wide", c_ovf_count, 20);
        check("sat_ovf_narrow", s_ovf_count, 15);

        // Abort mid-READOUT
        start_run(10);
        repeat (16) tick();
        det_q = '{8'd12, 8'd12, 8'd12};
        acquire(10);
        c_rd_ready = 1'b1;
        tick();
        tick();
        check("abort_pre_bin", c_rd_bin, 2);
        c_rst = 1'b1;
        tick();
        c_rst      = 1'b0;
        c_rd_ready = 1'b0;
        check("abort_busy", c_busy, 0);
        check("abort_valid", c_rd_valid, 0);
        check("abort_done", c_done, 0);
        check("abort_ovf", c_ovf_count, 0);
        check("abort_snap", c_period_snap, 0);
        check("abort_bin", c_rd_bin, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_done", c_done, 0);
        end

        // Fresh run clears old contents; c_start during ACQUIRE is ignored
        start_run(5);
        repeat (16) tick();
        for (int k = 0; k < 5; k++) begin
            c_start = (k == 2);
            tick();
        end
        c_start = 1'b0;
        readout(0);
        clear_exp();
        check_hists();
        check("final_ovf", c_ovf_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/micromotion_histogram.md
Name: micromotion_histogram

Overview:
Downstream consumer of the micromotion detector's photon-timing outputs (c_detect, c_diff, c_ch2_period). It bins each photon's delay from the RF-reference rising edge into a phase histogram over a programmable integration window. It then streams the histogram out over a valid/ready interface to the readout/host path. The histogram correlation amplitude is the micromotion figure of merit.

Parameters:
DATASIZE, 8, width of c_diff and c_ch2_period; matches the upstream detector.
NBINS_LOG2, 4, log2 of the number of histogram bins (16 bins by default).
BIN_SHIFT, 2, right shift applied to c_diff to form the bin index (4 clocks per bin).
COUNTSIZE, 16, width of each bin counter and of the overflow counter.
WINSIZE, 32, width of the integration-window length.

Ports:
c_clk  in  1  system clock; all logic on rising edge.
c_rst  in  1  synchronous, active-high reset.
c_detect  in  1  one-clock photon-detected pulse from the upstream stage.
c_diff  in  DATASIZE  photon delay in clocks, valid when c_detect=1.
c_ch2_period  in  DATASIZE  current RF-reference period in clocks.
c_start  in  1  one-clock request to begin clear+acquire+readout.
c_win_len  in  WINSIZE  acquisition length in clocks; sampled on an accepted c_start.
c_busy  out  1  high in any state other than IDLE.
c_rd_valid  out  1  readout word valid.
c_rd_ready  in  1  consumer accepts the word when valid&ready.
c_rd_bin  out  NBINS_LOG2  bin index of the current word.
c_rd_count  out  COUNTSIZE  bin count of the current word.
c_rd_last  out  1  high with the final bin word.
c_ovf_count  out  COUNTSIZE  photons in the last acquisition whose bin was out of range.
c_period_snap  out  DATASIZE  c_ch2_period captured on the last ACQUIRE cycle.
c_done  out  1  one-clock pulse after the last word is accepted.

Behaviour:
- Reset (synchronous): state=IDLE, all outputs 0, window counter 0, readout pointer 0. Bin-array contents are undefined after reset; they are cleared only by the CLEAR state.
- States and transitions:
  - IDLE -> CLEAR on c_start.
  - CLEAR -> ACQUIRE after NBINS cycles.
  - ACQUIRE -> READOUT after the window expires.
  - READOUT -> IDLE on acceptance of the last word.
- c_start in IDLE at cycle t:
  - c_win_len is latched; c_win_len=0 is treated as 1.
  - c_busy goes high at t+1.
  - CLEAR occupies t+1..t+NBINS, zeroing one bin per cycle (bin i at t+1+i). c_ovf_count is zeroed at t+1.
- c_start outside IDLE is ignored.
- ACQUIRE lasts exactly W cycles (W = latched length).
  - Every cycle with c_detect=1 in ACQUIRE counts one photon. Detects in CLEAR, READOUT or IDLE are dropped.
  - Bin index: b = c_diff >> BIN_SHIFT. If b < NBINS, bin[b] += 1; otherwise c_ovf_count += 1.
  - Both counters saturate at 2^COUNTSIZE-1 and never wrap.
  - An update is visible from the cycle after the detect.
  - Detects on consecutive cycles, including to the same bin, must all be counted. No lost updates.
- c_period_snap is loaded from c_ch2_period on the final ACQUIRE cycle.
- READOUT:
  - On the first READOUT cycle, c_rd_valid=1 with bin 0.
  - The word is held stable while valid & !ready.
  - On valid&ready the pointer advances; the next word is presented the following cycle, so 1 word/clock is possible when ready stays high.
  - c_rd_last=1 only with bin NBINS-1.
  - On acceptance of the last word: c_rd_valid drops next cycle, c_done pulses for that one cycle, state=IDLE, c_busy=0.
  - Histogram contents and c_ovf_count hold until the next CLEAR.
- c_rst asserted in any state (including mid-ACQUIRE or mid-READOUT) returns to IDLE the next cycle with outputs at reset values. No c_done is produced.
- No combinational path from c_rd_ready to c_rd_valid.

Test Plan:
- Reset/idle: hold c_rst 3 cycles, release -> all outputs 0, c_busy=0. Pulse c_detect with c_diff=5 -> no counts (verify by a later run showing zero).
- Basic binning: start with c_win_len=100; during ACQUIRE send detects at c_diff=0, 3, 4, 63, 64 -> bin0=2, bin1=1, bin15=1, c_ovf_count=1. Readout produces 16 words in bins 0..15; c_rd_last on bin 15; c_done pulses once.
- Back-to-back: 10 consecutive-cycle detects all with c_diff=9 -> bin2=10, no lost updates.
- Window edges: c_win_len=0 -> ACQUIRE exactly 1 cycle. A detect on the cycle after ACQUIRE ends is not counted. c_period_snap equals c_ch2_period=200 on the last ACQUIRE cycle.
- Backpressure: toggle c_rd_ready randomly -> every word is held stable while stalled; sequence bins 0..15 with no drops or duplicates. With ready=1 constant, 16 words arrive in 16 consecutive cycles.
- Saturation/abort: COUNTSIZE=4 with 20 detects to bin 1 -> count 15. c_rst asserted mid-READOUT -> IDLE next cycle, no c_done. A new c_start clears the previous histogram to zero.
